// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: 1..4 players, BCD scores, lives, frame timer,
// pause and end-of-game winner detection.

// Per-player lane: saturating BCD score increment and lives decrement.
module pong_lane #(
    parameter int SCORE_DIGITS = 2,
    parameter int LIVES_W      = 2
) (
    input  logic                      hit_i,
    input  logic                      miss_i,
    input  logic [SCORE_DIGITS*4-1:0] score_i,
    input  logic [LIVES_W-1:0]        lives_i,
    output logic [SCORE_DIGITS*4-1:0] score_o,
    output logic [LIVES_W-1:0]        lives_o,
    output logic                      dead_o
);
    logic all_nines;
    logic carry;

    // BCD ripple increment; an all-nines score holds instead of wrapping
    always_comb begin
        all_nines = 1'b1;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (score_i[d*4 +: 4] != 4'd9) all_nines = 1'b0;
        end
        carry   = hit_i & ~all_nines;
        score_o = score_i;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (carry) begin
                if (score_i[d*4 +: 4] == 4'd9) begin
                    score_o[d*4 +: 4] = 4'd0;
                end else begin
                    score_o[d*4 +: 4] = score_i[d*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Lives drop by one per miss, never below zero; dead when a miss empties them
    always_comb begin
        lives_o = lives_i;
        if (miss_i && (lives_i != '0)) lives_o = lives_i - LIVES_W'(1);
        dead_o = miss_i && (lives_o == '0);
    end
endmodule

module pong_game_ctrl #(
    parameter int NUM_PLAYERS  = 2,
    parameter int LIVES        = 3,
    parameter int LIVES_W      = 2,
    parameter int SCORE_DIGITS = 2,
    parameter int SERVE_FRAMES = 120,
    parameter int OVER_FRAMES  = 120,
    parameter int TIMER_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 frame_tick,
    input  logic                                 start,
    input  logic                                 pause,
    input  logic [NUM_PLAYERS-1:0]               hit,
    input  logic [NUM_PLAYERS-1:0]               miss,
    output logic [2:0]                           state,
    output logic                                 gra_still,
    output logic [NUM_PLAYERS*SCORE_DIGITS*4-1:0] score,
    output logic [NUM_PLAYERS*LIVES_W-1:0]       lives,
    output logic [1:0]                           serve_player,
    output logic [NUM_PLAYERS-1:0]               winner,
    output logic                                 timer_busy
);
    localparam int SW = SCORE_DIGITS * 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_SERVE = 3'd2,
        S_OVER  = 3'd3,
        S_PAUSE = 3'd4
    } state_e;

    state_e                                 state_q, state_d;
    logic [NUM_PLAYERS-1:0][SW-1:0]         score_q, score_d, score_nxt;
    logic [NUM_PLAYERS-1:0][LIVES_W-1:0]    lives_q, lives_d, lives_nxt, lives_init;
    logic [NUM_PLAYERS-1:0]                 dead;
    logic [NUM_PLAYERS-1:0]                 winner_q, winner_d, win_calc;
    logic [TIMER_W-1:0]                     timer_q, timer_d;
    logic [1:0]                             serve_q, serve_d, miss_idx;
    logic [SW-1:0]                          max_score;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
        pong_lane #(
            .SCORE_DIGITS (SCORE_DIGITS),
            .LIVES_W      (LIVES_W)
        ) u_lane (
            .hit_i   (hit[i]),
            .miss_i  (miss[i]),
            .score_i (score_q[i]),
            .lives_i (lives_q[i]),
            .score_o (score_nxt[i]),
            .lives_o (lives_nxt[i]),
            .dead_o  (dead[i])
        );
    end

    // Winner from post-hit scores, lowest missing player and reload value for lives
    always_comb begin
        max_score = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (score_nxt[i] > max_score) max_score = score_nxt[i];
        end
        win_calc = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            win_calc[i] = (score_nxt[i] == max_score);
        end
        miss_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (miss[i]) miss_idx = 2'(i);
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            lives_init[i] = LIVES_W'(LIVES);
        end
    end

    // Game-flow next state; timer counts frames unless loaded or paused
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        lives_d  = lives_q;
        winner_d = winner_q;
        serve_d  = serve_q;
        timer_d  = (frame_tick && (timer_q != '0)) ? timer_q - TIMER_W'(1) : timer_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_PLAY;
                    score_d  = '0;
                    lives_d  = lives_init;
                    winner_d = '0;
                    serve_d  = '0;
                end
            end
            S_PLAY: begin
                score_d = score_nxt;
                if (|miss) begin
                    lives_d = lives_nxt;
                    serve_d = miss_idx;
                    if (|dead) begin
                        state_d  = S_OVER;
                        timer_d  = TIMER_W'(OVER_FRAMES);
                        winner_d = win_calc;
                    end else begin
                        state_d = S_SERVE;
                        timer_d = TIMER_W'(SERVE_FRAMES);
                    end
                end else if (pause) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                timer_d = timer_q;
                if (pause) state_d = S_PLAY;
            end
            S_SERVE: begin
                if ((timer_q == '0) && start) state_d = S_PLAY;
            end
            S_OVER: begin
                if (timer_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            score_q  <= '0;
            lives_q  <= lives_init;
            winner_q <= '0;
            serve_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            winner_q <= winner_d;
            serve_q  <= serve_d;
            timer_q  <= timer_d;
        end
    end

    assign state        = state_q;
    assign gra_still    = (state_q != S_PLAY);
    assign score        = score_q;
    assign lives        = lives_q;
    assign serve_player = serve_q;
    assign winner       = winner_q;
    assign timer_busy   = (timer_q != '0);
endmodule
